// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for a single MAC: buffers W/X vectors, clears the MAC,
// streams len operand pairs, then returns the accumulator over valid/ready.
module mac_operand_sequencer #(
    parameter int DW      = 4,
    parameter int AW      = 8,
    parameter int MAX_LEN = 4,
    parameter int LW      = $clog2(MAX_LEN) + 1,
    parameter int IW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          err,
    output logic [DW-1:0] mac_w,
    output logic [DW-1:0] mac_x,
    output logic          mac_load,
    output logic          mac_clear,
    input  logic [AW-1:0] mac_acc,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data
);

    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, HOLD} state_t;

    state_t                    state;
    logic [MAX_LEN-1:0][DW-1:0] w_buf;
    logic [MAX_LEN-1:0][DW-1:0] x_buf;
    logic [LW-1:0]             len_q;
    logic [LW-1:0]             idx;
    logic                      len_ok;

    assign len_ok = (len != '0) && (len <= LW'(MAX_LEN));

    // idx names the next element to present; it equals len_q on the last STREAM cycle
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            w_buf     <= '0;
            x_buf     <= '0;
            len_q     <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mac_w     <= '0;
            mac_x     <= '0;
            mac_load  <= 1'b0;
            mac_clear <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (wr_sel) x_buf[wr_addr] <= wr_data;
                        else        w_buf[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        if (len_ok) begin
                            len_q     <= len;
                            busy      <= 1'b1;
                            mac_clear <= 1'b1;
                            state     <= CLR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    mac_clear <= 1'b0;
                    mac_load  <= 1'b1;
                    mac_w     <= w_buf[0];
                    mac_x     <= x_buf[0];
                    idx       <= LW'(1);
                    state     <= STREAM;
                end
                STREAM: begin
                    if (idx == len_q) begin
                        mac_load <= 1'b0;
                        mac_w    <= '0;
                        mac_x    <= '0;
                        state    <= DRAIN;
                    end else begin
                        mac_w <= w_buf[idx[IW-1:0]];
                        mac_x <= x_buf[idx[IW-1:0]];
                        idx   <= idx + LW'(1);
                    end
                end
                DRAIN: begin
                    // last load landed on the edge that entered DRAIN
                    res_data  <= mac_acc;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Driver side of the MAC accumulator interface: holds one W vector and one X vector of up to MAX_LEN 4-bit elements.
- On a start command it clears the MAC, then streams the operand pairs with load asserted.
- Captures the final 8-bit accumulator value and returns it over a valid/ready result handshake.
- Sits between the matrix-multiply controller (writes operands, issues start) and one MAC instance.

Parameters:
DW, 4, operand width (w, x)
AW, 8, accumulator width
MAX_LEN, 4, vector buffer depth; LW = clog2(MAX_LEN)+1 = 3

Ports:
clk  input  1  clock, rising edge
clear  input  1  reset, asynchronous, active-high
wr_en  input  1  write one operand element (accepted only when busy=0)
wr_sel  input  1  0 = W buffer, 1 = X buffer
wr_addr  input  2  element index 0..MAX_LEN-1
wr_data  input  DW  element value
start  input  1  begin dot product (accepted only in IDLE)
len  input  LW  number of element pairs, legal 1..MAX_LEN
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse: start with illegal len
mac_w  output  DW  operand w to MAC
mac_x  output  DW  operand x to MAC
mac_load  output  1  MAC accumulates w*x on this edge
mac_clear  output  1  MAC zeroes its accumulator on this edge
mac_acc  input  AW  MAC registered accumulator output
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  AW  captured dot product

Behaviour:
- Reset:
  - Async on clear=1.
  - State IDLE; both buffers all 0; busy, err, mac_load, mac_clear, res_valid = 0; mac_w, mac_x, res_data = 0; index and length registers 0.
  - Reset in any state, including mid-STREAM, aborts the job; no result is produced.
- MAC contract:
  - mac_clear=1 at an edge sets acc to 0.
  - Otherwise mac_load=1 at an edge sets acc to acc + w*x, truncated to AW bits (wraps mod 256).
  - mac_acc reflects the new value after that edge.
- Writes:
  - In IDLE, wr_en stores wr_data into buffer[wr_sel][wr_addr] at the edge.
  - Writes while busy=1 are ignored.
- FSM, all outputs registered:
  - IDLE: start=1 with 1<=len<=MAX_LEN → latch len, go CLR. start with len=0 or len>MAX_LEN → err=1 for one cycle, stay IDLE, no MAC activity. A write in the same cycle as start is performed.
  - CLR (1 cycle): mac_clear=1, mac_load=0 → STREAM with idx=0.
  - STREAM (exactly len cycles): mac_load=1, mac_w=W[idx], mac_x=X[idx]. idx increments each cycle. After the cycle with idx=len-1 → DRAIN.
  - DRAIN (1 cycle): mac_load=0, mac_w=mac_x=0. mac_acc holds the final sum; capture into res_data at the end of the cycle → HOLD.
  - HOLD: res_valid=1, res_data stable. When res_valid && res_ready at an edge → res_valid=0, go IDLE.
- Outside CLR and STREAM, mac_load and mac_clear are 0 and mac_w and mac_x are 0.
- Latency: start accepted at edge E0 → res_valid high after edge E0+len+2. A len=4 job gives res_valid in the 7th cycle after start.
- Edge cases:
  - start while busy is ignored, including in HOLD concurrent with res_ready; it must be re-issued in IDLE.
  - res_ready while res_valid=0 is ignored.
  - Buffer contents persist across jobs until overwritten.
- Width: products are DW×DW = 8 bits. Overflow of the sum wraps; no flag.

Test Plan:
- W={15,3,5,8}, X={15,2,3,1}, len=4, res_ready=1 → mac_clear for 1 cycle, then 4 load cycles; res_data=254 (225, 231, 246, 254), res_valid 1 cycle.
- W0=7, X0=9, len=1 → res_data=63. Latency from the start edge is 3 edges.
- W={15,15}, X={15,15}, len=2 → res_data=194 (450 mod 256).
- Back-pressure: res_ready=0 for 5 cycles after res_valid → res_valid and res_data=254 held. Issue start during HOLD → ignored. Raise res_ready → IDLE next edge, busy=0.
- len=0, then len=5 → err pulse each time; mac_clear and mac_load never assert; busy stays 0.
- Assert clear during the 2nd STREAM cycle → all outputs 0 immediately, buffers 0. A new job after release with freshly written data gives the correct sum. A write during busy leaves the buffer unchanged.
